// File: rtl/regfile_wr_arbiter_if.sv
// Writeback-side bundle for the regfile write-port arbiter: two requesters,
// the hold control, the registered regfile write stage and the conflict counter.
interface regfile_wr_arbiter_if #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int CNTW    = 8
);
   logic               hold;
   logic               req0_valid;
   logic               req0_ready;
   logic [REGBITS-1:0] req0_wa;
   logic [WIDTH-1:0]   req0_wd;
   logic               req1_valid;
   logic               req1_ready;
   logic [REGBITS-1:0] req1_wa;
   logic [WIDTH-1:0]   req1_wd;
   logic               regwrite;
   logic [REGBITS-1:0] wa;
   logic [WIDTH-1:0]   wd;
   logic               last_grant;
   logic [CNTW-1:0]    conflict_cnt;

   modport master (
      output hold, req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
      input  req0_ready, req1_ready, regwrite, wa, wd, last_grant, conflict_cnt
   );

   modport slave (
      input  hold, req0_valid, req0_wa, req0_wd, req1_valid, req1_wa, req1_wd,
      output req0_ready, req1_ready, regwrite, wa, wd, last_grant, conflict_cnt
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the regfile write port between ALU and load writeback.
// Optional macro RFARB_ZERO_DROP_EN: accepted writes to register 0 complete but do not write.
module regfile_wr_arbiter #(
   parameter int WIDTH   = 8,
   parameter int REGBITS = 3,
   parameter int CNTW    = 8
) (
   input logic                  clk,
   input logic                  reset,
   regfile_wr_arbiter_if.slave  bus
);
   logic               prio;
   logic               grant0;
   logic               grant1;
   logic               slot_en;
   logic [REGBITS-1:0] sel_wa;
   logic [WIDTH-1:0]   sel_wd;
   logic               regwrite_q;
   logic [REGBITS-1:0] wa_q;
   logic [WIDTH-1:0]   wd_q;
   logic               last_grant_q;
   logic [CNTW-1:0]    conflict_q;

   // On a tie the requester matching prio wins; hold blocks both grants.
   assign grant0 = ~bus.hold & bus.req0_valid & (~bus.req1_valid | ~prio);
   assign grant1 = ~bus.hold & bus.req1_valid & (~bus.req0_valid |  prio);

   assign sel_wa = grant1 ? bus.req1_wa : bus.req0_wa;
   assign sel_wd = grant1 ? bus.req1_wd : bus.req0_wd;

`ifdef RFARB_ZERO_DROP_EN
   assign slot_en = (sel_wa != '0);
`else
   assign slot_en = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prio         <= 1'b0;
         regwrite_q   <= 1'b0;
         wa_q         <= '0;
         wd_q         <= '0;
         last_grant_q <= 1'b0;
         conflict_q   <= '0;
      end else begin
         if (grant0 | grant1) begin
            regwrite_q   <= slot_en;
            wa_q         <= sel_wa;
            wd_q         <= sel_wd;
            last_grant_q <= grant1;
            prio         <= grant0;
         end else begin
            regwrite_q   <= 1'b0;
         end
         if (bus.req0_valid & bus.req1_valid & ~bus.hold & ~(&conflict_q))
            conflict_q <= conflict_q + 1'b1;
      end
   end

   assign bus.req0_ready   = grant0;
   assign bus.req1_ready   = grant1;
   assign bus.regwrite     = regwrite_q;
   assign bus.wa           = wa_q;
   assign bus.wd           = wd_q;
   assign bus.last_grant   = last_grant_q;
   assign bus.conflict_cnt = conflict_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a small regfile model behind the write port.
module tb_regfile_wr_arbiter;
   logic clk;
   logic reset;
   int   tests;
   int   fails;
   logic [7:0] rf [8];

   regfile_wr_arbiter_if #(.WIDTH(8), .REGBITS(3), .CNTW(8)) bus ();

   regfile_wr_arbiter #(.WIDTH(8), .REGBITS(3), .CNTW(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (bus.regwrite) rf[bus.wa] <= bus.wd;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v0, input logic [2:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [2:0] a1, input logic [7:0] d1,
                        input logic h);
      bus.req0_valid = v0; bus.req0_wa = a0; bus.req0_wd = d0;
      bus.req1_valid = v1; bus.req1_wa = a1; bus.req1_wd = d1;
      bus.hold = h;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0);
      #10;
      chk("rst_regwrite", bus.regwrite, 1'b0);
      chk("rst_wa", bus.wa, 3'd0);
      chk("rst_wd", bus.wd, 8'h00);
      chk("rst_last_grant", bus.last_grant, 1'b0);
      chk("rst_conflict", bus.conflict_cnt, 8'd0);
      #1 reset = 1'b0;
      tick();

      // single ALU write
      drive(1, 3'd3, 8'h5A, 0, 0, 0, 0);
      chk("t2_ready0", bus.req0_ready, 1'b1);
      chk("t2_ready1", bus.req1_ready, 1'b0);
      tick();
      chk("t2_regwrite", bus.regwrite, 1'b1);
      chk("t2_wa", bus.wa, 3'd3);
      chk("t2_wd", bus.wd, 8'h5A);
      chk("t2_last_grant", bus.last_grant, 1'b0);

      // reset pulse to restart with prio=0
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1 reset = 1'b0;
      tick();

      // round robin under contention
      drive(1, 3'd1, 8'h01, 1, 3'd2, 8'h02, 0);
      chk("t3_a_ready0", bus.req0_ready, 1'b1);
      chk("t3_a_ready1", bus.req1_ready, 1'b0);
      tick();
      chk("t3_a_wd", bus.wd, 8'h01);
      chk("t3_a_lg", bus.last_grant, 1'b0);
      chk("t3_a_cnt", bus.conflict_cnt, 8'd1);
      drive(1, 3'd3, 8'h03, 1, 3'd2, 8'h02, 0);
      chk("t3_b_ready1", bus.req1_ready, 1'b1);
      chk("t3_b_ready0", bus.req0_ready, 1'b0);
      tick();
      chk("t3_b_wd", bus.wd, 8'h02);
      chk("t3_b_lg", bus.last_grant, 1'b1);
      chk("t3_b_cnt", bus.conflict_cnt, 8'd2);
      drive(1, 3'd3, 8'h03, 1, 3'd4, 8'h04, 0);
      chk("t3_c_ready0", bus.req0_ready, 1'b1);
      tick();
      chk("t3_c_wd", bus.wd, 8'h03);
      chk("t3_c_lg", bus.last_grant, 1'b0);
      chk("t3_c_cnt", bus.conflict_cnt, 8'd3);
      drive(0, 0, 0, 1, 3'd4, 8'h04, 0);
      chk("t3_d_ready1", bus.req1_ready, 1'b1);
      tick();
      chk("t3_d_regwrite", bus.regwrite, 1'b1);
      chk("t3_d_wa", bus.wa, 3'd4);
      chk("t3_d_wd", bus.wd, 8'h04);
      chk("t3_d_lg", bus.last_grant, 1'b1);
      chk("t3_d_cnt", bus.conflict_cnt, 8'd3);

      // async reset in the middle of a live slot
      drive(0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      chk("t1_regwrite", bus.regwrite, 1'b0);
      chk("t1_conflict", bus.conflict_cnt, 8'd0);
      chk("t1_wa", bus.wa, 3'd0);
      reset = 1'b0;
      tick();

      // same-address collision, loser's data lands last
      drive(1, 3'd5, 8'h11, 1, 3'd5, 8'h22, 0);
      chk("t4_ready0", bus.req0_ready, 1'b1);
      tick();
      chk("t4_first_wd", bus.wd, 8'h11);
      chk("t4_first_lg", bus.last_grant, 1'b0);
      drive(0, 0, 0, 1, 3'd5, 8'h22, 0);
      tick();
      chk("t4_second_wd", bus.wd, 8'h22);
      chk("t4_second_lg", bus.last_grant, 1'b1);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      chk("t4_reg5", rf[5], 8'h22);
      chk("t4_idle_regwrite", bus.regwrite, 1'b0);

      // hold freezes arbitration and conflict counting
      for (int i = 0; i < 3; i++) begin
         drive(1, 3'd6, 8'h66, 1, 3'd7, 8'h77, 1);
         chk("t5_hold_ready0", bus.req0_ready, 1'b0);
         chk("t5_hold_ready1", bus.req1_ready, 1'b0);
         tick();
         chk("t5_hold_regwrite", bus.regwrite, 1'b0);
         chk("t5_hold_cnt", bus.conflict_cnt, 8'd1);
      end
      chk("t5_hold_wd_kept", bus.wd, 8'h22);
      drive(1, 3'd6, 8'h66, 1, 3'd7, 8'h77, 0);
      chk("t5_rel_ready0", bus.req0_ready, 1'b1);
      tick();
      chk("t5_rel_wd", bus.wd, 8'h66);
      chk("t5_rel_lg", bus.last_grant, 1'b0);
      chk("t5_rel_cnt", bus.conflict_cnt, 8'd2);
      drive(0, 0, 0, 1, 3'd7, 8'h77, 0);
      chk("t5_rel_ready1", bus.req1_ready, 1'b1);
      tick();
      chk("t5_rel2_wd", bus.wd, 8'h77);
      chk("t5_rel2_wa", bus.wa, 3'd7);

      // write to register 0
      drive(0, 0, 0, 1, 3'd0, 8'hFF, 0);
      chk("t6_ready1", bus.req1_ready, 1'b1);
      tick();
`ifdef RFARB_ZERO_DROP_EN
      chk("t6_regwrite", bus.regwrite, 1'b0);
`else
      chk("t6_regwrite", bus.regwrite, 1'b1);
      chk("t6_wa", bus.wa, 3'd0);
      chk("t6_wd", bus.wd, 8'hFF);
`endif

      // saturation of the conflict counter (starts at 2)
      drive(1, 3'd1, 8'hA0, 1, 3'd2, 8'hB0, 0);
      for (int i = 0; i < 252; i++) tick();
      chk("sat_254", bus.conflict_cnt, 8'd254);
      tick();
      chk("sat_255", bus.conflict_cnt, 8'd255);
      for (int i = 0; i < 46; i++) tick();
      chk("sat_hold_255", bus.conflict_cnt, 8'd255);
      drive(0, 0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
